// File: rtl/bpm2per.sv
// Tempo-to-period converter: per_o = floor(DIVIDEND / bpm_i) in milliseconds,
// produced by a one-bit-per-cycle restoring divider behind a valid/busy handshake.
module bpm2per #(
    parameter int unsigned BPM_W    = 9,
    parameter int unsigned PER_W    = 16,
    parameter int unsigned DIVIDEND = 60000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BPM_W-1:0] bpm_i,
    input  logic             bpm_valid,
    output logic [PER_W-1:0] per_o,
    output logic             per_valid,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    localparam int unsigned CNT_W = $clog2(PER_W + 1);

    if (DIVIDEND >= (64'd1 << PER_W)) begin : g_bad_dividend
        $error("bpm2per: DIVIDEND must be smaller than 2**PER_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: a request is taken on any rising edge where bpm_valid = 1,
    // busy_o = 0 and rst_i = 0; requests seen while busy_o = 1 are dropped,
    // not queued. per_valid pulses for one cycle when per_o is refreshed.
    state_t             state_q, state_d;
    logic [BPM_W-1:0]   div_q, div_d;
    logic [PER_W-1:0]   dvd_q, dvd_d;
    logic [BPM_W:0]     rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic               per_valid_q, per_valid_d;
    logic               busy_q, busy_d;

    logic [BPM_W+1:0]   rem_sh;
    logic [BPM_W+1:0]   trial;
    logic               take;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        per_valid_d = 1'b0;
        busy_d      = busy_q;

        rem_sh = {rem_q, dvd_q[PER_W-1]};
        trial  = rem_sh - {2'b00, div_q};
        // A zero divisor always "fits", which yields an all-ones quotient.
        take   = ~trial[BPM_W+1] | (div_q == '0);

        case (state_q)
            IDLE: begin
                if (bpm_valid) begin
                    div_d   = bpm_i;
                    dvd_d   = PER_W'(DIVIDEND);
                    rem_d   = '0;
                    cnt_d   = CNT_W'(PER_W);
                    state_d = DIV;
                    busy_d  = 1'b1;
                end
            end
            DIV: begin
                // The dividend register fills with quotient bits from the bottom.
                dvd_d = {dvd_q[PER_W-2:0], take};
                rem_d = take ? trial[BPM_W:0] : rem_sh[BPM_W:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                per_d       = dvd_q;
                per_valid_d = 1'b1;
                state_d     = IDLE;
                busy_d      = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            per_q       <= '0;
            per_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            per_valid_q <= per_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign per_o     = per_q;
    assign per_valid = per_valid_q;
    assign busy_o    = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_bpm2per.sv
// Directed bench for bpm2per: reset, nominal and zero-divisor conversions,
// busy drops, reset abort and back-to-back throughput with an expected queue.
module tb_bpm2per;

    localparam int BPM_W = 9;
    localparam int PER_W = 16;
    localparam int LAT   = PER_W + 1;
    localparam int BUDGET = 60;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [BPM_W-1:0] bpm = '0;
    logic             bpm_valid = 1'b0;
    logic [PER_W-1:0] per_o;
    logic             per_valid;
    logic             busy_o;
    logic [1:0]       state_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [PER_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    bpm2per #(.BPM_W(BPM_W), .PER_W(PER_W), .DIVIDEND(60000)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bpm_i     (bpm),
        .bpm_valid (bpm_valid),
        .per_o     (per_o),
        .per_valid (per_valid),
        .busy_o    (busy_o),
        .state_o   (state_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            bpm = 9'd120;
            bpm_valid = (i != 1);
            step();
            vec_cnt++;
            if ({per_o, per_valid, busy_o} !== {16'd0, 1'b0, 1'b0}) begin
                err_cnt++;
                $display("FAIL reset_hold[%0d]: per_o=%0d per_valid=%b busy=%b, want 0/0/0", i, per_o, per_valid, busy_o);
            end
        end
        rst = 1'b0;
        bpm_valid = 1'b0;
        step();
        vec_cnt++;
        if ({per_o, per_valid, busy_o, state_o} !== {16'd0, 1'b0, 1'b0, 2'd0}) begin
            err_cnt++;
            $display("FAIL reset_release: per_o=%0d per_valid=%b busy=%b state=%0d, want 0/0/0/0", per_o, per_valid, busy_o, state_o);
        end
    endtask

    task automatic test_nominal();
        logic [BPM_W-1:0] tab_bpm [6] = '{9'd120, 9'd250, 9'd1, 9'd7, 9'd511, 9'd0};
        logic [PER_W-1:0] tab_per [6] = '{16'd500, 16'd240, 16'd60000, 16'd8571, 16'd117, 16'd65535};
        for (int t = 0; t < 6; t++) begin
            int lat;
            int busy_gap;
            bpm = tab_bpm[t];
            bpm_valid = 1'b1;
            step();
            bpm_valid = 1'b0;
            bpm = '1;
            lat = 0;
            busy_gap = 0;
            do begin
                if (busy_o !== 1'b1) busy_gap++;
                step();
                lat++;
            end while (per_valid !== 1'b1 && lat < BUDGET);
            vec_cnt++;
            if (lat != LAT) begin
                err_cnt++;
                $display("FAIL conv_latency bpm=%0d: got %0d edges, want %0d", tab_bpm[t], lat, LAT);
            end
            vec_cnt++;
            if (per_o !== tab_per[t]) begin
                err_cnt++;
                $display("FAIL conv_value bpm=%0d: per_o=%0d, want %0d", tab_bpm[t], per_o, tab_per[t]);
            end
            vec_cnt++;
            if (busy_gap != 0 || busy_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL conv_busy bpm=%0d: low-while-busy=%0d busy_at_pulse=%b, want 0/0", tab_bpm[t], busy_gap, busy_o);
            end
            step();
            vec_cnt++;
            if (per_valid !== 1'b0 || per_o !== tab_per[t]) begin
                err_cnt++;
                $display("FAIL conv_hold bpm=%0d: per_valid=%b per_o=%0d, want 0/%0d", tab_bpm[t], per_valid, per_o, tab_per[t]);
            end
        end
    endtask

    task automatic test_busy_drop();
        int pulses;
        int lat;
        bpm = 9'd120;
        bpm_valid = 1'b1;
        step();                                 // edge N
        bpm_valid = 1'b0;
        for (int i = 1; i < 5; i++) step();     // edges N+1..N+4
        bpm = 9'd60;
        bpm_valid = 1'b1;
        step();                                 // edge N+5, dropped
        bpm_valid = 1'b0;
        for (int i = 6; i <= 16; i++) step();   // through edge N+16
        vec_cnt++;
        if (state_o !== 2'd2) begin
            err_cnt++;
            $display("FAIL drop_done_state: state=%0d, want 2", state_o);
        end
        bpm_valid = 1'b1;
        step();                                 // edge N+17, dropped in DONE
        bpm_valid = 1'b0;
        vec_cnt++;
        if (per_valid !== 1'b1 || per_o !== 16'd500) begin
            err_cnt++;
            $display("FAIL drop_result: per_valid=%b per_o=%0d, want 1/500", per_valid, per_o);
        end
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (per_valid === 1'b1 || busy_o !== 1'b0) pulses++;
        end
        vec_cnt++;
        if (pulses != 0 || per_o !== 16'd500) begin
            err_cnt++;
            $display("FAIL drop_no_second: extra activity=%0d per_o=%0d, want 0/500", pulses, per_o);
        end
        bpm = 9'd60;
        bpm_valid = 1'b1;
        step();
        bpm_valid = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (per_valid !== 1'b1 && lat < BUDGET);
        vec_cnt++;
        if (lat != LAT || per_o !== 16'd1000) begin
            err_cnt++;
            $display("FAIL drop_retry: latency=%0d per_o=%0d, want %0d/1000", lat, per_o, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int lat;
        bpm = 9'd100;
        bpm_valid = 1'b1;
        step();                                 // edge N
        bpm_valid = 1'b0;
        for (int i = 1; i < 8; i++) step();
        rst = 1'b1;
        step();                                 // edge N+8
        rst = 1'b0;
        vec_cnt++;
        if ({per_o, per_valid, busy_o, state_o} !== {16'd0, 1'b0, 1'b0, 2'd0}) begin
            err_cnt++;
            $display("FAIL abort_state: per_o=%0d per_valid=%b busy=%b state=%0d, want 0/0/0/0", per_o, per_valid, busy_o, state_o);
        end
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (per_valid === 1'b1) pulses++;
        end
        vec_cnt++;
        if (pulses != 0 || per_o !== 16'd0) begin
            err_cnt++;
            $display("FAIL abort_no_pulse: pulses=%0d per_o=%0d, want 0/0", pulses, per_o);
        end
        bpm_valid = 1'b1;
        step();
        bpm_valid = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (per_valid !== 1'b1 && lat < BUDGET);
        vec_cnt++;
        if (lat != LAT || per_o !== 16'd600) begin
            err_cnt++;
            $display("FAIL abort_retry: latency=%0d per_o=%0d, want %0d/600", lat, per_o, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [BPM_W-1:0] tab [3] = '{9'd60, 9'd90, 9'd180};
        logic [PER_W-1:0] last_per;
        int issued;
        int got;
        int cyc;
        int last_pulse;
        int unstable;
        step();
        exp_q = {16'd1000, 16'd666, 16'd333};
        issued = 0;
        got = 0;
        cyc = 0;
        last_pulse = -1;
        unstable = 0;
        last_per = per_o;
        while (got < 3 && cyc < 200) begin
            if (issued < 3 && busy_o === 1'b0) begin
                bpm = tab[issued];
                bpm_valid = 1'b1;
                issued++;
            end else begin
                bpm_valid = 1'b0;
            end
            step();
            cyc++;
            if (per_valid === 1'b1) begin
                logic [PER_W-1:0] exp_v;
                exp_v = exp_q.pop_front();
                vec_cnt++;
                if (per_o !== exp_v) begin
                    err_cnt++;
                    $display("FAIL b2b_value[%0d]: per_o=%0d, want %0d", got, per_o, exp_v);
                end
                if (last_pulse >= 0) begin
                    vec_cnt++;
                    if (cyc - last_pulse != PER_W + 2) begin
                        err_cnt++;
                        $display("FAIL b2b_spacing[%0d]: gap=%0d, want %0d", got, cyc - last_pulse, PER_W + 2);
                    end
                end
                last_pulse = cyc;
                last_per = per_o;
                got++;
            end else if (per_o !== last_per) begin
                unstable++;
            end
        end
        bpm_valid = 1'b0;
        vec_cnt++;
        if (got != 3 || exp_q.size() != 0 || unstable != 0) begin
            err_cnt++;
            $display("FAIL b2b_summary: results=%0d left=%0d unstable=%0d, want 3/0/0", got, exp_q.size(), unstable);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_busy_drop();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

endmodule
